bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//  Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble).
//  Performs one shift per clock and applies add-3 (digit >=5 -> +3) to every BCD digit.
//  Optional signed mode converts the two's-complement magnitude and flags the sign.
//  Sits between binary datapath results and the 7-segment/display drivers.
//  Replaces the combinational add-3 cell array for wide operands.
// PARAMETERS
//  BIN_W   16  binary input width in bits; must be >= 2.
//  DIGITS  5   number of BCD output digits; oBcd is 4*DIGITS bits wide.
//  SIGNED  0   0: iBin is unsigned. 1: iBin is two's complement and the magnitude is converted.
// PORTS
//  iClk    in   1          clock; all state changes on the rising edge.
//  iReset  in   1          synchronous, active-high reset.
//  iStart  in   1          request a conversion; sampled only in IDLE.
//  iBin    in   BIN_W      binary operand; captured in the cycle iStart is accepted.
//  oBusy   out  1          high while converting.
//  oDone   out  1          one-cycle pulse; oBcd, oNeg and oOvf are valid from this cycle.
//  oBcd    out  4*DIGITS   result; digit k is oBcd[4k+3:4k], with k=0 the least significant.
//  oNeg    out  1          SIGNED=1: operand was negative. Tied 0 when SIGNED=0.
//  oOvf    out  1          result did not fit in DIGITS digits.
// BEHAVIOUR
//  Reset: iReset high at an edge forces state IDLE.
//   All outputs go to 0 and internal shift/BCD registers clear.
//   This applies at any point, including mid-conversion; the aborted conversion never raises oDone.
//  FSM states: IDLE, CONV.
//   IDLE -> CONV when iStart=1. CONV -> IDLE after the BIN_W-th shift.
//  Load (edge S, IDLE with iStart=1):
//   - Shift register <= magnitude(iBin). When SIGNED=1 and iBin is negative, magnitude = -iBin
//     computed in BIN_W bits; -2^(BIN_W-1) yields 2^(BIN_W-1) unsigned.
//   - Working BCD <= 0, overflow sticky <= 0, sign <= MSB(iBin) & SIGNED.
//   - Counter <= BIN_W. oBusy <= 1.
//  CONV (each edge):
//   - Each working digit: d >= 5 -> d+3, else unchanged.
//   - Then {BCD, shift reg} shifts left by 1.
//   - Any 1 shifted out of the top digit sets the overflow sticky.
//   - Counter decrements.
//  Completion: the edge performing shift BIN_W (edge S+BIN_W) also does all of:
//   - writes oBcd, oNeg, oOvf;
//   - sets oDone=1, oBusy=0;
//   - returns to IDLE.
//  Latency: oDone is high in the cycle following edge S+BIN_W, i.e. BIN_W cycles after acceptance.
//  Outputs: oBcd, oNeg and oOvf hold their values until the next completion or reset.
//   oDone is exactly one cycle wide.
//  iStart while oBusy=1 is ignored; no queuing, and iBin is not re-sampled.
//  Back-to-back: iStart=1 in the oDone cycle (state IDLE) is accepted.
//  Overflow: when oOvf=1, oBcd holds the magnitude mod 10^DIGITS; lower digits are exact.
//   With DIGITS >= ceil(BIN_W*log10(2)), oOvf never asserts.
//  Digit range: pre-adjust digits are always 0..9; post-adjust values are 0..4 or 8..12,
//   so no digit carry is needed beyond the shift.
// TESTING
//  1. BIN_W=16, DIGITS=5, iBin=16'hFFFF, iStart pulse
//     -> oDone 16 cycles later, oBcd=20'h65535, oOvf=0.
//  2. iBin=0 -> oBcd=0. Also iBin=1, 9, 10, 99, 100 -> 0x1, 0x9, 0x10, 0x99, 0x100 (exhaustive sweep 0..65535 vs model).
//  3. SIGNED=1, BIN_W=16: iBin=16'h8000 -> oNeg=1, oBcd=20'h32768.
//     iBin=16'hFFFF -> oNeg=1, oBcd=20'h00001.
//  4. DIGITS=4, iBin=12345 -> oBcd=16'h2345, oOvf=1. Then iBin=9999 -> oOvf=0.
//  5. iStart held high for 40 cycles, iBin changing each cycle
//     -> conversions of only the values present at each acceptance edge.
//     oDone every 17 cycles (16 CONV + 1 IDLE); iBin changes while oBusy have no effect.
//  6. iReset pulsed at CONV cycle 7 -> outputs 0 next cycle and no oDone.
//     A following iStart converts correctly.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one shift per clock.
// Optional signed mode converts the two's-complement magnitude and reports the sign.
module bin2bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 0
) (
    input  logic                  iClk,
    input  logic                  iReset,
    input  logic                  iStart,
    input  logic [BIN_W-1:0]      iBin,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [4*DIGITS-1:0]   oBcd,
    output logic                  oNeg,
    output logic                  oOvf
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               sign_q, sign_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
    logic               neg_out_q, neg_out_d;
    logic               ovf_out_q, ovf_out_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic signed [BIN_W-1:0] bin_s;
    logic                    neg_in;
    logic [BCD_W-1:0]        adj;
    logic [BCD_W+BIN_W:0]    sh;

    // Digits are always 0..9 before adjustment, so a 4-bit add never carries.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int k = 0; k < DIGITS; k++) begin
            if (b[4*k +: 4] >= 4'd5)
                r[4*k +: 4] = b[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign bin_s  = iBin;
    assign neg_in = (SIGNED != 0) && iBin[BIN_W-1];
    assign adj    = add3(bcd_q);
    assign sh     = {adj, shift_q, 1'b0};

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        sign_d    = sign_q;
        cnt_d     = cnt_q;
        bcd_out_d = bcd_out_q;
        neg_out_d = neg_out_q;
        ovf_out_d = ovf_out_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (iStart) begin
                    state_d = CONV;
                    // -2^(BIN_W-1) wraps to itself, which reads correctly as unsigned.
                    shift_d = neg_in ? $unsigned(-bin_s) : iBin;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    sign_d  = neg_in;
                    cnt_d   = CNT_W'(BIN_W);
                    busy_d  = 1'b1;
                end
            end
            CONV: begin
                bcd_d   = sh[BCD_W+BIN_W-1 -: BCD_W];
                shift_d = sh[BIN_W-1:0];
                ovf_d   = ovf_q | sh[BCD_W+BIN_W];
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = IDLE;
                    bcd_out_d = sh[BCD_W+BIN_W-1 -: BCD_W];
                    neg_out_d = sign_q;
                    ovf_out_d = ovf_q | sh[BCD_W+BIN_W];
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            sign_q    <= 1'b0;
            cnt_q     <= '0;
            bcd_out_q <= '0;
            neg_out_q <= 1'b0;
            ovf_out_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            sign_q    <= sign_d;
            cnt_q     <= cnt_d;
            bcd_out_q <= bcd_out_d;
            neg_out_q <= neg_out_d;
            ovf_out_q <= ovf_out_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign oBusy = busy_q;
    assign oDone = done_q;
    assign oBcd  = bcd_out_q;
    assign oNeg  = neg_out_q;
    assign oOvf  = ovf_out_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: unsigned, signed and narrow-output instances.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
    logic [15:0] bin0 = '0, bin1 = '0, bin2 = '0;
    logic        busy0, busy1, busy2, done0, done1, done2;
    logic        neg0, neg1, neg2, ovf0, ovf1, ovf2;
    logic [19:0] bcd0, bcd1;
    logic [15:0] bcd2;

    int total = 0;
    int bad = 0;

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u0 (
        .iClk(clk), .iReset(rst), .iStart(st0), .iBin(bin0),
        .oBusy(busy0), .oDone(done0), .oBcd(bcd0), .oNeg(neg0), .oOvf(ovf0));
    bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1)) u1 (
        .iClk(clk), .iReset(rst), .iStart(st1), .iBin(bin1),
        .oBusy(busy1), .oDone(done1), .oBcd(bcd1), .oNeg(neg1), .oOvf(ovf1));
    bin2bcd_seq #(.BIN_W(16), .DIGITS(4), .SIGNED(0)) u2 (
        .iClk(clk), .iReset(rst), .iStart(st2), .iBin(bin2),
        .oBusy(busy2), .oDone(done2), .oBcd(bcd2), .oNeg(neg2), .oOvf(ovf2));

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Pulse iStart on one instance and wait (bounded) for its oDone.
    task automatic run(input int which, input logic [15:0] v, output logic [19:0] bcd,
                       output logic neg, output logic ovf, output int lat);
        logic d;
        @(negedge clk);
        case (which)
            0: begin st0 = 1'b1; bin0 = v; end
            1: begin st1 = 1'b1; bin1 = v; end
            default: begin st2 = 1'b1; bin2 = v; end
        endcase
        @(negedge clk);
        st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        lat = 0;
        d = 1'b0;
        while (!d && lat < 40) begin
            @(negedge clk);
            lat++;
            d = (which == 0) ? done0 : (which == 1) ? done1 : done2;
        end
        case (which)
            0: begin bcd = bcd0; neg = neg0; ovf = ovf0; end
            1: begin bcd = bcd1; neg = neg1; ovf = ovf1; end
            default: begin bcd = {4'h0, bcd2}; neg = neg2; ovf = ovf2; end
        endcase
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total++;
        if ({busy0, done0, neg0, ovf0, bcd0} !== 24'h0) begin
            bad++;
            $display("FAIL reset_u0 got busy=%b done=%b neg=%b ovf=%b bcd=%h want all 0",
                     busy0, done0, neg0, ovf0, bcd0);
        end
        total++;
        if ({busy1, done1, neg1, ovf1, bcd1} !== 24'h0) begin
            bad++;
            $display("FAIL reset_u1 got busy=%b done=%b neg=%b ovf=%b bcd=%h want all 0",
                     busy1, done1, neg1, ovf1, bcd1);
        end
    endtask

    task automatic test_unsigned();
        logic [15:0] vin [9]  = '{16'hFFFF, 16'd0, 16'd1, 16'd9, 16'd10, 16'd99, 16'd100, 16'd12345, 16'd40000};
        logic [19:0] vexp [9] = '{20'h65535, 20'h0, 20'h1, 20'h9, 20'h10, 20'h99, 20'h100, 20'h12345, 20'h40000};
        logic [19:0] b;
        logic n, o;
        int lat;
        for (int i = 0; i < 9; i++) begin
            run(0, vin[i], b, n, o, lat);
            total++;
            if (lat !== 16) begin
                bad++;
                $display("FAIL uns_latency in=%0d got %0d cycles want 16", vin[i], lat);
            end
            total++;
            if (b !== vexp[i] || o !== 1'b0 || n !== 1'b0) begin
                bad++;
                $display("FAIL uns_value in=%0d got bcd=%h ovf=%b neg=%b want bcd=%h ovf=0 neg=0",
                         vin[i], b, o, n, vexp[i]);
            end
        end
        @(negedge clk);
        total++;
        if (done0 !== 1'b0 || bcd0 !== 20'h40000) begin
            bad++;
            $display("FAIL uns_hold got done=%b bcd=%h want done=0 bcd=40000", done0, bcd0);
        end
    endtask

    task automatic test_signed();
        logic [15:0] vin [4]  = '{16'h8000, 16'hFFFF, 16'd123, 16'h7FFF};
        logic [19:0] vexp [4] = '{20'h32768, 20'h00001, 20'h00123, 20'h32767};
        logic        nexp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [19:0] b;
        logic n, o;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run(1, vin[i], b, n, o, lat);
            total++;
            if (b !== vexp[i] || n !== nexp[i] || o !== 1'b0 || lat !== 16) begin
                bad++;
                $display("FAIL signed in=%h got bcd=%h neg=%b ovf=%b lat=%0d want bcd=%h neg=%b ovf=0 lat=16",
                         vin[i], b, n, o, lat, vexp[i], nexp[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [19:0] b;
        logic n, o;
        int lat;
        run(2, 16'd12345, b, n, o, lat);
        total++;
        if (b !== 20'h02345 || o !== 1'b1) begin
            bad++;
            $display("FAIL ovf_12345 got bcd=%h ovf=%b want bcd=2345 ovf=1", b, o);
        end
        run(2, 16'd9999, b, n, o, lat);
        total++;
        if (b !== 20'h09999 || o !== 1'b0) begin
            bad++;
            $display("FAIL ovf_9999 got bcd=%h ovf=%b want bcd=9999 ovf=0", b, o);
        end
        run(2, 16'd65535, b, n, o, lat);
        total++;
        if (b !== 20'h05535 || o !== 1'b1) begin
            bad++;
            $display("FAIL ovf_65535 got bcd=%h ovf=%b want bcd=5535 ovf=1", b, o);
        end
    endtask

    // iStart held high: acceptances fall on edges 0, 17 and 34 of the loop.
    task automatic test_back_to_back();
        int ndone = 0;
        logic exp_done;
        for (int i = 0; i <= 52; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp_done = (i == 17) || (i == 34) || (i == 51);
                total++;
                if (done0 !== exp_done) begin
                    bad++;
                    $display("FAIL b2b_done i=%0d got %b want %b", i, done0, exp_done);
                end
                if (done0 === 1'b1) begin
                    ndone++;
                    total++;
                    if (bcd0 !== to_bcd(1000 + 7 * (i - 17))) begin
                        bad++;
                        $display("FAIL b2b_value i=%0d got %h want %h", i, bcd0, to_bcd(1000 + 7 * (i - 17)));
                    end
                end
                if (i == 10) begin
                    total++;
                    if (busy0 !== 1'b1) begin
                        bad++;
                        $display("FAIL b2b_busy got %b want 1", busy0);
                    end
                end
            end
            st0  = (i < 40);
            bin0 = 16'(1000 + 7 * i);
        end
        st0 = 1'b0;
        total++;
        if (ndone !== 3) begin
            bad++;
            $display("FAIL b2b_count got %0d want 3", ndone);
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] b;
        logic n, o;
        int lat;
        int seen = 0;
        @(negedge clk);
        st0 = 1'b1; bin0 = 16'd4321;
        @(negedge clk);
        st0 = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({busy0, done0, neg0, ovf0, bcd0} !== 24'h0) begin
            bad++;
            $display("FAIL midreset_clear got busy=%b done=%b ovf=%b bcd=%h want all 0",
                     busy0, done0, ovf0, bcd0);
        end
        repeat (20) begin
            @(negedge clk);
            if (done0 === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midreset_nodone got %0d done pulses want 0", seen);
        end
        run(0, 16'd4321, b, n, o, lat);
        total++;
        if (b !== 20'h04321 || lat !== 16) begin
            bad++;
            $display("FAIL midreset_after got bcd=%h lat=%0d want bcd=04321 lat=16", b, lat);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
